instr_fetch_stage: RTL and testbench

//  Stage-0 fetch unit: owns the PC, reads a synchronous instruction ROM, and drives the 32-bit word plus write-enable

---
 rtl/instr_fetch_stage_pkg.sv | 32 +++
 rtl/instr_fetch_stage_if.sv | 25 ++
 rtl/instr_fetch_stage_hold_buf.sv | 40 ++++
 rtl/instr_fetch_stage.sv | 114 +++++++++++
 tb/tb_instr_fetch_stage.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared fetch/decode definitions: instruction fields, HALT code, FSM states.
// Imported by the fetch stage, its hold buffer and the decode stage.
package instr_fetch_stage_pkg;

  localparam int DATASRC_BIT = 29;
  localparam int ALUOP_HI    = 28;
  localparam int ALUOP_LO    = 26;
  localparam int WSEL_HI     = 25;
  localparam int WSEL_LO     = 21;
  localparam int RSEL1_HI    = 20;
  localparam int RSEL1_LO    = 16;
  localparam int RSEL2_HI    = 15;
  localparam int RSEL2_LO    = 11;
  localparam int IMM_HI      = 15;
  localparam int IMM_LO      = 0;

  localparam logic [1:0]  HALT_CODE = 2'b11;
  localparam logic [31:0] NOP_WORD  = 32'h0;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(
    input logic [31:0] word,
    input logic [1:0]  code
  );
    return word[31:30] == code;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Fetch -> decode link: InstrIn/WriteEnable bundle plus stall/redirect back.
// master = fetch (producer), slave = decode (consumer).
interface instr_fetch_stage_if #(
  parameter int AW = 8
);

  logic [31:0]   instr_out;
  logic          write_enable_out;
  logic [AW-1:0] pc_out;
  logic          halted;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  modport master (
    output instr_out, write_enable_out, pc_out, halted,
    input  stall, redirect, redirect_pc
  );

  modport slave (
    input  instr_out, write_enable_out, pc_out, halted,
    output stall, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_stage_hold_buf.sv
// Skid register: keeps the ROM word that arrives on the first stall cycle.
// Ports: clk/rst, capture, clear, rdata in; hold_buf/hold_valid out.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic [31:0] hold_buf,
  output logic        hold_valid
);

  logic [31:0] hold_buf_q, hold_buf_d;
  logic        hold_valid_q, hold_valid_d;

  always_comb begin
    hold_buf_d   = hold_buf_q;
    hold_valid_d = hold_valid_q;
    if (clear) begin
      hold_valid_d = 1'b0;
    end else if (capture) begin
      hold_buf_d   = rdata;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_buf_q   <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_buf_q   <= hold_buf_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign hold_buf   = hold_buf_q;
  assign hold_valid = hold_valid_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Stage-0 fetch: PC, sync ROM read, stall skid, redirect, HALT freeze.
// Ports: clk, rst, imem_addr/imem_rdata (ROM), bus (master side to decode).
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int            AW        = 8,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter logic [1:0]    HALT_CODE = instr_fetch_stage_pkg::HALT_CODE
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [AW-1:0]         imem_addr,
  input  logic [31:0]           imem_rdata,
  instr_fetch_stage_if.master   bus
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_pend_q, pc_pend_d;
  logic          pend_q, pend_d;
  logic [31:0]   instr_q, instr_d;
  logic          we_q, we_d;
  logic [AW-1:0] pc_out_q, pc_out_d;

  logic [31:0] hold_buf;
  logic        hold_valid;
  logic [31:0] word;
  logic        halt_deliv;
  logic        capture;
  logic        clear;

  assign word = hold_valid ? hold_buf : imem_rdata;

  assign halt_deliv = !bus.redirect && !bus.stall && pend_q &&
                      is_halt(word, HALT_CODE);

  // Grab the in-flight word only once; later stall cycles see mem[pc].
  assign capture = bus.stall && pend_q && !hold_valid;
  assign clear   = bus.redirect || !bus.stall;

  fetch_hold_buf u_hold (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .clear      (clear),
    .rdata      (imem_rdata),
    .hold_buf   (hold_buf),
    .hold_valid (hold_valid)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_pend_d = pc_pend_q;
    pend_d    = pend_q;
    instr_d   = instr_q;
    we_d      = we_q;
    pc_out_d  = pc_out_q;
    if (bus.redirect) begin
      state_d = S_RUN;
      pc_d    = bus.redirect_pc;
      pend_d  = 1'b0;
      instr_d = NOP_WORD;
      we_d    = 1'b0;
    end else if (!bus.stall) begin
      if (pend_q) begin
        instr_d  = word;
        pc_out_d = pc_pend_q;
        we_d     = (word != NOP_WORD) && !is_halt(word, HALT_CODE);
      end else begin
        instr_d = NOP_WORD;
        we_d    = 1'b0;
      end
      // HALT squashes the fetch that would issue on the same edge.
      if (halt_deliv) begin
        state_d = S_HALT;
        pend_d  = 1'b0;
      end else if (state_q == S_RUN) begin
        pc_d      = pc_q + AW'(1);
        pc_pend_d = pc_q;
        pend_d    = 1'b1;
      end else begin
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      pc_pend_q <= '0;
      pend_q    <= 1'b0;
      instr_q   <= NOP_WORD;
      we_q      <= 1'b0;
      pc_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_pend_q <= pc_pend_d;
      pend_q    <= pend_d;
      instr_q   <= instr_d;
      we_q      <= we_d;
      pc_out_q  <= pc_out_d;
    end
  end

  assign imem_addr            = pc_q;
  assign bus.instr_out        = instr_q;
  assign bus.write_enable_out = we_q;
  assign bus.pc_out           = pc_out_q;
  assign bus.halted           = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a synchronous ROM model.
// Checks reset, latency, stall, redirect, NOP, HALT, wrap and reset-in-stall.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] rom [256];

  int checks   = 0;
  int failures = 0;

  instr_fetch_stage_if #(.AW(8)) bus ();

  instr_fetch_stage #(.AW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) imem_rdata <= rom[imem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] i,
                         input logic w, input logic [7:0] p);
    chk({tag, "_instr"}, bus.instr_out, i);
    chk({tag, "_we"}, {31'b0, bus.write_enable_out}, {31'b0, w});
    chk({tag, "_pc"}, {24'b0, bus.pc_out}, {24'b0, p});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h0100_0000 + i * 32'h0001_0101;
    rom[0] = 32'h2443_0005;
    rom[1] = 32'h0865_1000;
    rom[5] = 32'h0000_0000;
    rom[6] = 32'hC000_0000;

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    step(); step();
    chk_out("reset", 32'h0, 1'b0, 8'h00);
    chk("reset_halted", {31'b0, bus.halted}, 32'h0);
    chk("reset_addr", {24'b0, imem_addr}, 32'h0);

    rst = 1'b0;
    step();
    chk_out("lat_e1", 32'h0, 1'b0, 8'h00);
    step();
    chk_out("first", 32'h2443_0005, 1'b1, 8'h00);
    step();
    chk_out("second", 32'h0865_1000, 1'b1, 8'h01);

    bus.stall = 1'b1;
    step(); chk_out("stall1", 32'h0865_1000, 1'b1, 8'h01);
    step(); chk_out("stall2", 32'h0865_1000, 1'b1, 8'h01);
    step(); chk_out("stall3", 32'h0865_1000, 1'b1, 8'h01);
    bus.stall = 1'b0;
    step(); chk_out("rel_w2", rom[2], 1'b1, 8'h02);
    step(); chk_out("rel_w3", rom[3], 1'b1, 8'h03);
    step(); chk_out("rel_w4", rom[4], 1'b1, 8'h04);
    step(); chk_out("nop_w5", 32'h0, 1'b0, 8'h05);
    step(); chk_out("halt_w6", 32'hC000_0000, 1'b0, 8'h06);
    chk("halt_flag", {31'b0, bus.halted}, 32'h1);
    chk("halt_addr0", {24'b0, imem_addr}, 32'h7);
    step();
    chk("halt_bub_i", bus.instr_out, 32'h0);
    chk("halt_bub_we", {31'b0, bus.write_enable_out}, 32'h0);
    chk("halt_addr1", {24'b0, imem_addr}, 32'h7);
    step();
    chk("halt_still", {31'b0, bus.halted}, 32'h1);
    chk("halt_addr2", {24'b0, imem_addr}, 32'h7);

    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h00;
    step();
    bus.redirect = 1'b0;
    chk("unhalt", {31'b0, bus.halted}, 32'h0);
    chk("unhalt_bub", bus.instr_out, 32'h0);
    step();
    step();
    chk_out("rd0_w0", rom[0], 1'b1, 8'h00);
    step();
    chk_out("rd0_w1", rom[1], 1'b1, 8'h01);

    bus.redirect = 1'b1;
    bus.stall = 1'b1;
    bus.redirect_pc = 8'h40;
    step();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    chk_out("rd40_bub", 32'h0, 1'b0, 8'h01);
    step();
    chk("rd40_bub2", bus.instr_out, 32'h0);
    step();
    chk_out("rd40_w40", rom[8'h40], 1'b1, 8'h40);
    step();
    chk_out("rd40_w41", rom[8'h41], 1'b1, 8'h41);

    bus.redirect = 1'b1;
    bus.redirect_pc = 8'hFE;
    step();
    bus.redirect = 1'b0;
    step();
    step();
    chk_out("wrap_fe", rom[8'hFE], 1'b1, 8'hFE);
    step();
    chk_out("wrap_ff", rom[8'hFF], 1'b1, 8'hFF);
    step();
    chk_out("wrap_00", rom[0], 1'b1, 8'h00);

    bus.stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk_out("rst_stall", 32'h0, 1'b0, 8'h00);
    chk("rst_halted", {31'b0, bus.halted}, 32'h0);
    chk("rst_addr", {24'b0, imem_addr}, 32'h0);
    rst = 1'b0;
    bus.stall = 1'b0;
    step();
    step();
    chk_out("restart", rom[0], 1'b1, 8'h00);
    step();
    chk_out("restart1", rom[1], 1'b1, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
